// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory stage sitting directly behind the registered ALU. Loads and stores
//   use the ALU result as a byte address and run a req/ack access to data
//   memory; every other op forwards the ALU result to the register-file
//   writeback port with one cycle of latency. While an access is outstanding
//   the stage holds upstream with stall.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   in_valid        : alu_rslt and companion fields valid this cycle
//   in_opcode       : opcode aligned with alu_rslt
//   in_wen, in_rd   : instruction writes GPR in_rd
//   alu_rslt        : byte address for LW/SW, otherwise the result value
//   store_data      : SW write data
//   stall           : upstream must hold its current instruction
//   dmem_req/we/addr/wdata : memory request, held stable until dmem_ack
//   dmem_ack/rdata  : memory completion and load data
//   wb_valid/rd/data: register-file writeback (single-cycle pulse)
//   misalign        : one-cycle pulse for an LW/SW with a non-word address
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter logic [5:0] OP_LW = 6'h23,
    parameter logic [5:0] OP_SW = 6'h2B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [5:0]  in_opcode,
    input  logic        in_wen,
    input  logic [4:0]  in_rd,
    input  logic [31:0] alu_rslt,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic        r_we;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_misalign;
    // Destination of the outstanding load, captured at issue.
    logic [4:0]  r_ld_rd;
    logic        r_ld_wen;

    logic w_is_mem;
    logic w_is_store;
    logic w_aligned;

    assign w_is_store = (in_opcode == OP_SW);
    assign w_is_mem   = (in_opcode == OP_LW) || w_is_store;
    assign w_aligned  = (alu_rslt[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_misalign <= 1'b0;
            r_ld_rd    <= '0;
            r_ld_wen   <= 1'b0;
        end else begin
            // Writeback and misalign are pulses; default them low each cycle.
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_is_mem) begin
                            if (w_aligned) begin
                                r_state  <= BUSY;
                                r_req    <= 1'b1;
                                r_we     <= w_is_store;
                                r_addr   <= alu_rslt[31:2];
                                r_wdata  <= store_data;
                                r_ld_rd  <= in_rd;
                                r_ld_wen <= in_wen;
                            end else begin
                                r_misalign <= 1'b1;
                            end
                        end else begin
                            // GPR 0 is hardwired, so never report a write to it.
                            r_wb_valid <= in_wen && (in_rd != 5'd0);
                            r_wb_rd    <= in_rd;
                            r_wb_data  <= alu_rslt;
                        end
                    end
                end

                BUSY: begin
                    // in_valid is ignored here: upstream is stalled and will
                    // present its instruction again once we return to IDLE.
                    if (dmem_ack) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                        if (!r_we) begin
                            r_wb_valid <= r_ld_wen && (r_ld_rd != 5'd0);
                            r_wb_rd    <= r_ld_rd;
                            r_wb_data  <= dmem_rdata;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall      = (r_state == BUSY);
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign wb_valid   = r_wb_valid;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign misalign   = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//   Scoreboard bench for mem_stage. Stimulus pushes expected events (writeback,
//   misalign pulse, new memory request) into a queue; a monitor on the falling
//   edge pops and compares whenever the DUT presents one. The monitor also
//   compares stall/dmem_req against the expected busy flag every cycle and
//   checks that request fields stay stable while a request is pending.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    localparam int EV_WB  = 0;
    localparam int EV_MIS = 1;
    localparam int EV_REQ = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [5:0]  in_opcode;
    logic        in_wen;
    logic [4:0]  in_rd;
    logic [31:0] alu_rslt;
    logic [31:0] store_data;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [29:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;

    mem_stage #(.OP_LW(OP_LW), .OP_SW(OP_SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_opcode  (in_opcode),
        .in_wen     (in_wen),
        .in_rd      (in_rd),
        .alu_rslt   (alu_rslt),
        .store_data (store_data),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic [29:0] addr;
    } evt_t;

    evt_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [4:0] rd, input logic [31:0] data,
                        input logic we, input logic [29:0] addr);
        evt_t e;
        e.kind = kind;
        e.rd   = rd;
        e.data = data;
        e.we   = we;
        e.addr = addr;
        q.push_back(e);
    endtask

    task automatic expect_evt(input int kind, input logic [4:0] rd, input logic [31:0] data,
                              input logic we, input logic [29:0] addr);
        evt_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d with no expected event queued", kind);
        end else begin
            e = q.pop_front();
            check("event_kind", kind, e.kind);
            if (e.kind == kind) begin
                if (kind == EV_WB) begin
                    check("wb_rd", {27'd0, rd}, {27'd0, e.rd});
                    check("wb_data", data, e.data);
                end else if (kind == EV_REQ) begin
                    check("dmem_we", {31'd0, we}, {31'd0, e.we});
                    check("dmem_addr", {2'd0, addr}, {2'd0, e.addr});
                    check("dmem_wdata", data, e.data);
                end
            end
        end
    endtask

    // Monitor: decoupled from stimulus, samples on the falling edge.
    logic        prev_req = 1'b0;
    logic        prev_we;
    logic [29:0] prev_addr;
    logic [31:0] prev_wdata;

    always @(negedge clk) begin
        check("stall", {31'd0, stall}, {31'd0, exp_busy});
        check("dmem_req", {31'd0, dmem_req}, {31'd0, exp_busy});
        if (dmem_req === 1'b1 && prev_req === 1'b1) begin
            check("hold_we", {31'd0, dmem_we}, {31'd0, prev_we});
            check("hold_addr", {2'd0, dmem_addr}, {2'd0, prev_addr});
            check("hold_wdata", dmem_wdata, prev_wdata);
        end
        if (wb_valid === 1'b1)
            expect_evt(EV_WB, wb_rd, wb_data, 1'b0, 30'd0);
        if (misalign === 1'b1)
            expect_evt(EV_MIS, 5'd0, 32'd0, 1'b0, 30'd0);
        if (dmem_req === 1'b1 && prev_req !== 1'b1)
            expect_evt(EV_REQ, 5'd0, dmem_wdata, dmem_we, dmem_addr);
        prev_req   = dmem_req;
        prev_we    = dmem_we;
        prev_addr  = dmem_addr;
        prev_wdata = dmem_wdata;
    end

    // Non-memory op: one cycle in, writeback next cycle.
    task automatic alu_op(input logic [5:0] op, input logic wen, input logic [4:0] rd,
                          input logic [31:0] rslt);
        in_valid  = 1'b1;
        in_opcode = op;
        in_wen    = wen;
        in_rd     = rd;
        alu_rslt  = rslt;
        if (wen && rd != 5'd0)
            push(EV_WB, rd, rslt, 1'b0, 30'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Memory op; ack arrives on BUSY cycle d (d=1 means immediate ack).
    // The instruction stays presented during BUSY, as a stalled upstream would.
    task automatic mem_op(input logic sw, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic wen, input logic [4:0] rd, input int d,
                          input logic [31:0] rdata);
        in_valid   = 1'b1;
        in_opcode  = sw ? OP_SW : OP_LW;
        in_wen     = wen;
        in_rd      = rd;
        alu_rslt   = addr;
        store_data = sdata;
        if (addr[1:0] != 2'b00) begin
            push(EV_MIS, 5'd0, 32'd0, 1'b0, 30'd0);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end else begin
            push(EV_REQ, 5'd0, sdata, sw, addr[31:2]);
            for (int i = 1; i <= d; i++) begin
                @(posedge clk); #1;
                exp_busy   = 1'b1;
                dmem_ack   = (i == d);
                dmem_rdata = (i == d) ? rdata : 32'h0BAD_0BAD;
                if (i == d && !sw && wen && rd != 5'd0)
                    push(EV_WB, rd, rdata, 1'b0, 30'd0);
            end
            @(posedge clk); #1;
            exp_busy = 1'b0;
            dmem_ack = 1'b0;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_opcode  = 6'd0;
        in_wen     = 1'b0;
        in_rd      = 5'd0;
        alu_rslt   = 32'd0;
        store_data = 32'd0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        check("rst_dmem_addr", {2'd0, dmem_addr}, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);

        // Pass-through ops, including back-to-back.
        alu_op(6'h00, 1'b1, 5'd5, 32'h0000_1234);
        alu_op(6'h00, 1'b1, 5'd6, 32'h0000_55AA);
        alu_op(6'h09, 1'b1, 5'd7, 32'hFFFF_FFF0);
        alu_op(6'h09, 1'b1, 5'd0, 32'h0000_0007);    // rd=0: no writeback
        alu_op(6'h00, 1'b0, 5'd9, 32'h1111_1111);    // wen=0: no writeback
        repeat (2) @(posedge clk);
        #1;

        // Load with ack on the 3rd BUSY cycle.
        mem_op(1'b0, 32'h0000_0100, 32'h1111_2222, 1'b1, 5'd8, 3, 32'hDEAD_BEEF);
        // Store with immediate ack.
        mem_op(1'b1, 32'h0000_2000, 32'hCAFE_F00D, 1'b0, 5'd0, 1, 32'h0);
        // Misaligned load.
        mem_op(1'b0, 32'h0000_0102, 32'h0, 1'b1, 5'd3, 1, 32'h0);
        // Misaligned store.
        mem_op(1'b1, 32'h0000_0401, 32'h5555_AAAA, 1'b0, 5'd0, 1, 32'h0);
        // Load, load (re-presented on first IDLE cycle), then ALU op, no bubbles.
        mem_op(1'b0, 32'h0000_0010, 32'h0, 1'b1, 5'd10, 1, 32'h0123_4567);
        mem_op(1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 5'd11, 2, 32'h89AB_CDEF);
        mem_op(1'b0, 32'h0000_0020, 32'h0, 1'b1, 5'd0, 1, 32'h7777_7777);
        alu_op(6'h00, 1'b1, 5'd12, 32'h0000_00C0);

        // ack while IDLE has no side effect.
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h6666_6666;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the 2nd BUSY cycle of a load abandons the access.
        in_valid   = 1'b1;
        in_opcode  = OP_LW;
        in_wen     = 1'b1;
        in_rd      = 5'd4;
        alu_rslt   = 32'h0000_0300;
        store_data = 32'h0;
        push(EV_REQ, 5'd0, 32'h0, 1'b0, 30'h0C0);
        @(posedge clk); #1;
        exp_busy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        exp_busy = 1'b0;
        in_valid = 1'b0;
        check("rstbusy_dmem_addr", {2'd0, dmem_addr}, 32'd0);
        check("rstbusy_wb_data", wb_data, 32'd0);
        @(posedge clk); #1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h4444_4444;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Stage still works after the abandoned access.
        alu_op(6'h00, 1'b1, 5'd1, 32'h0000_A5A5);
        repeat (3) @(posedge clk);
        #1;

        check("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no end of stimulus expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Pipeline stage directly downstream of the registered ALU. It consumes the ALU result one cycle after the opcode is presented to the ALU. LW/SW results are treated as byte addresses for a data-memory access over a req/ack handshake. All other ops pass the result through, and the stage drives the register-file writeback port and a stall to upstream stages.

Parameters:
OP_LW, 6'h23, opcode value for load word
OP_SW, 6'h2B, opcode value for store word

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  alu_rslt and companion fields valid this cycle
in_opcode  input  6  opcode, delayed one cycle to align with alu_rslt
in_wen  input  1  instruction writes a GPR (R-type ALU, I-type ALU, LW)
in_rd  input  5  destination GPR index
alu_rslt  input  32  ALU result: byte address for LW/SW, else value
store_data  input  32  rt value for SW, aligned with alu_rslt
stall  output  1  upstream must hold its current instruction
dmem_req  output  1  memory request
dmem_we  output  1  1=store, 0=load; valid while dmem_req
dmem_addr  output  30  word address = alu_rslt[31:2]
dmem_wdata  output  32  store data
dmem_ack  input  1  memory completes the request this cycle
dmem_rdata  input  32  load data, valid when dmem_ack and !dmem_we
wb_valid  output  1  write wb_data to GPR wb_rd this cycle
wb_rd  output  5  writeback register index
wb_data  output  32  writeback value
misalign  output  1  one-cycle pulse: LW/SW with alu_rslt[1:0]!=0

Behaviour:
- Reset (synchronous, active-high): state=IDLE. stall, dmem_req, dmem_we, wb_valid and misalign are 0. dmem_addr, dmem_wdata, wb_rd and wb_data are 0. An outstanding access is abandoned; dmem_req falls on the cycle after rst is sampled.
- States: IDLE, BUSY.
- IDLE, in_valid=0: wb_valid=0 and misalign=0 next cycle.
- IDLE, in_valid=1, non-memory op: next cycle wb_valid=in_wen&&(in_rd!=0), wb_rd=in_rd, wb_data=alu_rslt. Latency is 1 cycle; back-to-back every cycle is allowed.
- IDLE, in_valid=1, LW/SW with alu_rslt[1:0]==0:
  - Next cycle: state=BUSY, dmem_req=1, dmem_we=(op==SW), dmem_addr=alu_rslt[31:2], dmem_wdata=store_data.
  - The stage latches in_rd and in_wen. wb_valid=0 that cycle.
- IDLE, in_valid=1, LW/SW with alu_rslt[1:0]!=0:
  - Next cycle: misalign=1 for one cycle.
  - No memory request, no writeback, state remains IDLE.
- BUSY:
  - stall=1, and stall is driven as (state==BUSY).
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until dmem_ack.
  - in_valid is ignored, because upstream is holding.
- BUSY, dmem_ack=1:
  - Next cycle: state=IDLE, dmem_req=0, stall=0.
  - Load: wb_valid=latched in_wen&&(rd!=0), wb_rd=latched rd, wb_data=dmem_rdata sampled on the ack cycle.
  - Store: wb_valid=0.
- dmem_ack may arrive on the first BUSY cycle. A load issued at cycle N with ack at N+1 produces wb_valid at N+2. stall is high on cycles N+1..ack cycle inclusive.
- dmem_ack while state==IDLE is ignored, with no side effect.
- The instruction held upstream is presented again with in_valid on the first IDLE cycle after BUSY. It is accepted that cycle, so a load followed by a load gives no bubble beyond the stall.
- wb_valid is a single-cycle pulse per instruction. wb_data is don't-care when wb_valid=0 but is held from its last write.

Test Plan:
- Reset then ADDU-aligned input: in_valid=1, op=0, in_wen=1, rd=5, alu_rslt=0x1234 at cycle N -> wb_valid=1, wb_rd=5, wb_data=0x1234 at N+1; stall stays 0.
- LW at alu_rslt=0x100, rd=8, ack at 3rd BUSY cycle with rdata=0xDEADBEEF -> dmem_req=1, dmem_we=0, dmem_addr=0x40 held 3 cycles; stall high 3 cycles; wb_data=0xDEADBEEF to rd 8 the cycle after ack.
- SW at alu_rslt=0x2000, store_data=0xCAFEF00D, immediate ack -> dmem_we=1, dmem_addr=0x800, dmem_wdata=0xCAFEF00D for 1 cycle; no wb_valid; stall high 1 cycle.
- LW at alu_rslt=0x102 -> misalign pulse 1 cycle; dmem_req, wb_valid and stall all stay 0.
- Write to rd=0 (ADDIU, rslt=7) -> wb_valid stays 0.
- rst asserted in the 2nd BUSY cycle of an LW -> next cycle dmem_req=0, stall=0, state IDLE. A later ack is ignored and produces no writeback.
